// File: rtl/cse_expr_pipe_if.sv
// cse_expr_pipe_if: operand/result handshake bundle for the shared-subexpression pipeline
interface cse_expr_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a, b, c, d, e, f, g, h;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result1, result2, result3, result4, result5, result6;
    logic [1:0]       occupancy;

    modport master (
        output in_valid, a, b, c, d, e, f, g, h, out_ready,
        input  in_ready, out_valid, result1, result2, result3, result4, result5, result6, occupancy
    );

    modport slave (
        input  in_valid, a, b, c, d, e, f, g, h, out_ready,
        output in_ready, out_valid, result1, result2, result3, result4, result5, result6, occupancy
    );
endinterface

// File: rtl/cse_expr_pipe.sv
// cse_expr_pipe: pipelined six-result datapath sharing A+B, C*D and E-F, with full backpressure
module cse_expr_pipe #(
    parameter int WIDTH   = 32,
    parameter bit REG_OUT = 1'b1
) (
    input logic            clk,
    input logic            rst,
    cse_expr_pipe_if.slave bus
);
    logic             w_adv1, w_adv2;
    logic             r_v1, r_v2;
    logic [WIDTH-1:0] r_s1_sab, r_s1_pcd, r_s1_def, r_s1_b, r_s1_c, r_s1_e, r_s1_f, r_s1_g, r_s1_h;
    logic [WIDTH-1:0] r_s2_r1, r_s2_r2, r_s2_t3, r_s2_t4a, r_s2_t5a, r_s2_t5b, r_s2_t6a, r_s2_sab, r_s2_def;
    logic [WIDTH-1:0] w_r4, w_r5, w_r6;

    assign w_adv1       = !r_v1 || w_adv2;
    assign bus.in_ready = w_adv1;
    assign w_r4         = r_s2_t4a * r_s2_sab;
    assign w_r5         = r_s2_t5a - r_s2_t5b;
    assign w_r6         = r_s2_t6a * r_s2_def;

    // Stage 1: form the three shared subexpressions and forward the raw operands still needed later
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1     <= 1'b0;
            r_s1_sab <= '0;
            r_s1_pcd <= '0;
            r_s1_def <= '0;
            r_s1_b   <= '0;
            r_s1_c   <= '0;
            r_s1_e   <= '0;
            r_s1_f   <= '0;
            r_s1_g   <= '0;
            r_s1_h   <= '0;
        end else if (w_adv1) begin
            r_v1     <= bus.in_valid;
            r_s1_sab <= bus.a + bus.b;
            r_s1_pcd <= bus.c * bus.d;
            r_s1_def <= bus.e - bus.f;
            r_s1_b   <= bus.b;
            r_s1_c   <= bus.c;
            r_s1_e   <= bus.e;
            r_s1_f   <= bus.f;
            r_s1_g   <= bus.g;
            r_s1_h   <= bus.h;
        end
    end

    // Stage 2: finish the additive results and prepare the operands of the final multiply/subtract
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v2     <= 1'b0;
            r_s2_r1  <= '0;
            r_s2_r2  <= '0;
            r_s2_t3  <= '0;
            r_s2_t4a <= '0;
            r_s2_t5a <= '0;
            r_s2_t5b <= '0;
            r_s2_t6a <= '0;
            r_s2_sab <= '0;
            r_s2_def <= '0;
        end else if (w_adv2) begin
            r_v2     <= r_v1;
            r_s2_r1  <= r_s1_sab + r_s1_pcd;
            r_s2_r2  <= r_s1_pcd + r_s1_def;
            r_s2_t3  <= r_s1_sab + r_s1_g + r_s1_h;
            r_s2_t4a <= r_s1_pcd + r_s1_e;
            r_s2_t5a <= r_s1_pcd + r_s1_b;
            r_s2_t5b <= r_s1_f + r_s1_sab;
            r_s2_t6a <= r_s1_sab + r_s1_c;
            r_s2_sab <= r_s1_sab;
            r_s2_def <= r_s1_def;
        end
    end

    generate
        if (REG_OUT) begin : g_reg
            logic             r_v3;
            logic             w_adv3;
            logic [WIDTH-1:0] r_r1, r_r2, r_r3, r_r4, r_r5, r_r6;

            assign w_adv3        = !r_v3 || bus.out_ready;
            assign w_adv2        = !r_v2 || w_adv3;
            assign bus.out_valid = r_v3;
            assign bus.result1   = r_r1;
            assign bus.result2   = r_r2;
            assign bus.result3   = r_r3;
            assign bus.result4   = r_r4;
            assign bus.result5   = r_r5;
            assign bus.result6   = r_r6;
            assign bus.occupancy = {1'b0, r_v1} + {1'b0, r_v2} + {1'b0, r_v3};

            // Stage 3: register the full result set so the consumer sees stable values under stall
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_v3 <= 1'b0;
                    r_r1 <= '0;
                    r_r2 <= '0;
                    r_r3 <= '0;
                    r_r4 <= '0;
                    r_r5 <= '0;
                    r_r6 <= '0;
                end else if (w_adv3) begin
                    r_v3 <= r_v2;
                    r_r1 <= r_s2_r1;
                    r_r2 <= r_s2_r2;
                    r_r3 <= r_s2_t3;
                    r_r4 <= w_r4;
                    r_r5 <= w_r5;
                    r_r6 <= w_r6;
                end
            end
        end else begin : g_comb
            assign w_adv2        = !r_v2 || bus.out_ready;
            assign bus.out_valid = r_v2;
            assign bus.result1   = r_s2_r1;
            assign bus.result2   = r_s2_r2;
            assign bus.result3   = r_s2_t3;
            assign bus.result4   = w_r4;
            assign bus.result5   = w_r5;
            assign bus.result6   = w_r6;
            assign bus.occupancy = {1'b0, r_v1} + {1'b0, r_v2};
        end
    endgenerate
endmodule

// File: tb/tb_cse_expr_pipe.sv
// tb_cse_expr_pipe: random + directed scoreboard bench for a registered 32-bit and a combinational-output 16-bit pipe
module tb_cse_expr_pipe;
    typedef logic [5:0][31:0] res_t;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    res_t q0[$];
    res_t q1[$];
    res_t held0, held1;
    logic st0, st1;

    always #5 clk = ~clk;

    cse_expr_pipe_if #(.WIDTH(32)) bus0 ();
    cse_expr_pipe_if #(.WIDTH(16)) bus1 ();

    cse_expr_pipe #(.WIDTH(32), .REG_OUT(1'b1)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    cse_expr_pipe #(.WIDTH(16), .REG_OUT(1'b0)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic res_t model(input logic [31:0] a, b, c, d, e, f, g, h, input logic [31:0] m);
        logic [31:0] sab, pcd, def;
        res_t r;
        sab  = a + b;
        pcd  = c * d;
        def  = e - f;
        r[0] = (sab + pcd) & m;
        r[1] = (pcd + def) & m;
        r[2] = (sab + g + h) & m;
        r[3] = ((pcd + e) * sab) & m;
        r[4] = ((pcd + b) - (f + sab)) & m;
        r[5] = ((sab + c) * def) & m;
        return r;
    endfunction

    task automatic set_ops(input logic v, input logic [31:0] a, b, c, d, e, f, g, h);
        bus0.in_valid = v;
        bus0.a = a; bus0.b = b; bus0.c = c; bus0.d = d;
        bus0.e = e; bus0.f = f; bus0.g = g; bus0.h = h;
        bus1.in_valid = v;
        bus1.a = a[15:0]; bus1.b = b[15:0]; bus1.c = c[15:0]; bus1.d = d[15:0];
        bus1.e = e[15:0]; bus1.f = f[15:0]; bus1.g = g[15:0]; bus1.h = h[15:0];
    endtask

    task automatic set_rand(input logic v);
        set_ops(v, $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom());
    endtask

    task automatic set_rdy(input logic r);
        bus0.out_ready = r;
        bus1.out_ready = r;
    endtask

    task automatic drain();
        int k = 0;
        set_ops(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_rdy(1'b1);
        while ((q0.size() != 0 || q1.size() != 0) && k < 30) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("drain", 64'(q0.size() + q1.size()), 64'd0);
    endtask

    // Scoreboard for the registered-output instance: occupancy, readiness, stall stability, ordered results
    always @(negedge clk) begin
        res_t obs, exp_r;
        if (rst) begin
            q0.delete();
            st0 = 1'b0;
        end else begin
            obs = {bus0.result6, bus0.result5, bus0.result4, bus0.result3, bus0.result2, bus0.result1};
            check("occ0", 64'(bus0.occupancy), 64'(q0.size()));
            check("in_ready0", 64'(bus0.in_ready), 64'(q0.size() < 3 || bus0.out_ready));
            if (st0) begin
                check("hold_valid0", 64'(bus0.out_valid), 64'd1);
                for (int j = 0; j < 6; j++) check($sformatf("hold0_r%0d", j + 1), 64'(obs[j]), 64'(held0[j]));
            end
            if (q0.size() == 0) check("idle_valid0", 64'(bus0.out_valid), 64'd0);
            else if (bus0.out_valid && bus0.out_ready) begin
                exp_r = q0.pop_front();
                for (int j = 0; j < 6; j++) check($sformatf("res0_r%0d", j + 1), 64'(obs[j]), 64'(exp_r[j]));
            end
            if (bus0.in_valid && bus0.in_ready)
                q0.push_back(model(bus0.a, bus0.b, bus0.c, bus0.d, bus0.e, bus0.f, bus0.g, bus0.h, 32'hFFFF_FFFF));
            st0   = bus0.out_valid && !bus0.out_ready;
            held0 = obs;
        end
    end

    // Scoreboard for the combinational-output 16-bit instance
    always @(negedge clk) begin
        res_t obs, exp_r;
        if (rst) begin
            q1.delete();
            st1 = 1'b0;
        end else begin
            obs = {16'h0, bus1.result6, 16'h0, bus1.result5, 16'h0, bus1.result4,
                   16'h0, bus1.result3, 16'h0, bus1.result2, 16'h0, bus1.result1};
            check("occ1", 64'(bus1.occupancy), 64'(q1.size()));
            check("in_ready1", 64'(bus1.in_ready), 64'(q1.size() < 2 || bus1.out_ready));
            if (st1) begin
                check("hold_valid1", 64'(bus1.out_valid), 64'd1);
                for (int j = 0; j < 6; j++) check($sformatf("hold1_r%0d", j + 1), 64'(obs[j]), 64'(held1[j]));
            end
            if (q1.size() == 0) check("idle_valid1", 64'(bus1.out_valid), 64'd0);
            else if (bus1.out_valid && bus1.out_ready) begin
                exp_r = q1.pop_front();
                for (int j = 0; j < 6; j++) check($sformatf("res1_r%0d", j + 1), 64'(obs[j]), 64'(exp_r[j]));
            end
            if (bus1.in_valid && bus1.in_ready)
                q1.push_back(model(32'(bus1.a), 32'(bus1.b), 32'(bus1.c), 32'(bus1.d),
                                   32'(bus1.e), 32'(bus1.f), 32'(bus1.g), 32'(bus1.h), 32'h0000_FFFF));
            st1   = bus1.out_valid && !bus1.out_ready;
            held1 = obs;
        end
    end

    initial begin
        int lat0, lat1, cnt0, cnt1;
        rst = 1'b1;
        set_rdy(1'b0);
        set_rand(1'b1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        set_ops(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("rst_in_ready0", 64'(bus0.in_ready), 64'd1);
        check("rst_out_valid0", 64'(bus0.out_valid), 64'd0);
        check("rst_occ0", 64'(bus0.occupancy), 64'd0);
        check("rst_r6_0", 64'(bus0.result6), 64'd0);
        check("rst_in_ready1", 64'(bus1.in_ready), 64'd1);
        check("rst_r1_1", 64'(bus1.result1), 64'd0);

        @(posedge clk);
        #1 set_rdy(1'b1);
        set_ops(1'b1, 1, 2, 3, 4, 5, 6, 7, 8);
        @(posedge clk);
        #1 set_ops(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
        lat0 = 0;
        lat1 = 0;
        for (int k = 1; k <= 8; k++) begin
            if (lat0 == 0 && bus0.out_valid) begin
                lat0 = k;
                check("basic_r1", 64'(bus0.result1), 64'd15);
                check("basic_r2", 64'(bus0.result2), 64'd11);
                check("basic_r3", 64'(bus0.result3), 64'd18);
                check("basic_r4", 64'(bus0.result4), 64'd51);
                check("basic_r5", 64'(bus0.result5), 64'd5);
                check("basic_r6", 64'(bus0.result6), 64'hFFFF_FFFA);
            end
            if (lat1 == 0 && bus1.out_valid) begin
                lat1 = k;
                check("basic16_r6", 64'(bus1.result6), 64'hFFFA);
            end
            @(posedge clk);
            #1;
        end
        check("latency0", 64'(lat0), 64'd3);
        check("latency1", 64'(lat1), 64'd2);
        drain();

        set_ops(1'b1, 32'hFFFF_FFFF, 1, 32'h0001_0000, 32'h0001_0000, 0, 0, 0, 0);
        @(posedge clk);
        #1 drain();

        cnt0 = 0;
        cnt1 = 0;
        for (int i = 1; i <= 13; i++) begin
            @(posedge clk);
            #1 set_ops(i <= 10, i, 1, 1, 1, 1, 1, 1, 1);
            @(negedge clk);
            cnt0 += int'(bus0.out_valid);
            cnt1 += int'(bus1.out_valid);
        end
        check("stream_count0", 64'(cnt0), 64'd10);
        check("stream_count1", 64'(cnt1), 64'd10);
        drain();

        set_rdy(1'b0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1 set_rand(1'b1);
        end
        @(negedge clk);
        check("bp_occ0", 64'(bus0.occupancy), 64'd3);
        check("bp_ready0", 64'(bus0.in_ready), 64'd0);
        check("bp_occ1", 64'(bus1.occupancy), 64'd2);
        check("bp_ready1", 64'(bus1.in_ready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1 set_rdy(1'b1);
            set_rand(1'b1);
        end
        @(posedge clk);
        #1 drain();

        set_rdy(1'b0);
        set_rand(1'b1);
        @(posedge clk);
        #1 set_rand(1'b1);
        @(posedge clk);
        #1 set_ops(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        set_rdy(1'b1);
        @(negedge clk);
        check("mid_out_valid0", 64'(bus0.out_valid), 64'd0);
        check("mid_occ0", 64'(bus0.occupancy), 64'd0);
        check("mid_r1_0", 64'(bus0.result1), 64'd0);
        check("mid_occ1", 64'(bus1.occupancy), 64'd0);
        check("mid_r4_1", 64'(bus1.result4), 64'd0);
        @(posedge clk);
        #1 set_rand(1'b1);
        @(posedge clk);
        #1 drain();

        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1 set_rdy($urandom_range(0, 3) != 0);
            set_rand($urandom_range(0, 2) != 0);
        end
        @(posedge clk);
        #1 drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
